// File: rtl/drum_pkg.sv
// Shared definitions for the drum machine: voice map, grid size, step timing.
package drum_pkg;

  localparam int NUM_VOICES = 4;
  localparam int NUM_STEPS  = 16;

  // Voice index map shared with the voice modules.
  localparam int VOICE_KICK  = 0;
  localparam int VOICE_SNARE = 1;
  localparam int VOICE_CHAT  = 2;
  localparam int VOICE_OHAT  = 3;

  typedef logic [15:0] step_period_t;

  // Sixteenth notes at 120 BPM with a 48 kHz audio tick.
  localparam step_period_t STEP_PERIOD_120BPM = 16'd6000;

  typedef enum logic {
    SEQ_IDLE = 1'b0,
    SEQ_RUN  = 1'b1
  } seq_state_t;

endpackage

// File: rtl/seq_pattern_ram.sv
// Voice x step on/off grid: synchronous write, combinational column read,
// cleared by the asynchronous reset.
module seq_pattern_ram #(
  parameter int NUM_VOICES = 4,
  parameter int NUM_STEPS  = 16
) (
  input  logic                          i_clk,
  input  logic                          i_reset,
  input  logic                          i_wr_en,
  input  logic [$clog2(NUM_VOICES)-1:0] i_wr_voice,
  input  logic [$clog2(NUM_STEPS)-1:0]  i_wr_step,
  input  logic                          i_wr_data,
  input  logic [$clog2(NUM_STEPS)-1:0]  i_rd_step,
  output logic [NUM_VOICES-1:0]         o_rd_col
);

  logic [NUM_VOICES-1:0][NUM_STEPS-1:0] r_grid;

  // Grid storage; a write lands after this edge, so same-edge reads see old data.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_grid <= '0;
    end else if (i_wr_en) begin
      r_grid[i_wr_voice][i_wr_step] <= i_wr_data;
    end
  end

  // Column read: one bit per voice at the requested step.
  always_comb begin
    o_rd_col = '0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      o_rd_col[v] = r_grid[v][i_rd_step];
    end
  end

endmodule

// File: rtl/drum_step_sequencer.sv
// Pattern step sequencer in the audio_tick domain. Fires one grid column per
// step, producing one-tick voice triggers, the open-hat choke and a step strobe.
module drum_step_sequencer
  import drum_pkg::*;
#(
  parameter int NUM_VOICES = drum_pkg::NUM_VOICES,
  parameter int NUM_STEPS  = drum_pkg::NUM_STEPS,
  parameter int CLOSED_HAT = VOICE_CHAT,
  parameter int OPEN_HAT   = VOICE_OHAT
) (
  input  logic                          audio_tick,
  input  logic                          reset,
  input  logic                          run,
  input  logic [15:0]                   step_period,
  input  logic [$clog2(NUM_STEPS)-1:0]  pattern_len,
  input  logic                          wr_en,
  input  logic [$clog2(NUM_VOICES)-1:0] wr_voice,
  input  logic [$clog2(NUM_STEPS)-1:0]  wr_step,
  input  logic                          wr_data,
  output logic [NUM_VOICES-1:0]         trigger,
  output logic                          choke,
  output logic                          step_strobe,
  output logic [$clog2(NUM_STEPS)-1:0]  step_index,
  output logic                          playing,
  output logic                          dbg_state
);

  localparam int STEP_W = $clog2(NUM_STEPS);
  localparam logic [STEP_W:0] FULL_LEN = (STEP_W+1)'(NUM_STEPS);

  seq_state_t r_state, w_state_nxt;
  step_period_t r_tick_cnt, w_tick_nxt;
  logic [STEP_W-1:0] r_step_index, w_idx_nxt;
  logic [NUM_VOICES-1:0] r_trigger, w_trig_nxt;
  logic r_choke, w_choke_nxt;
  logic r_step_strobe, w_strobe_nxt;
  logic r_playing;

  step_period_t w_period_m1;
  logic [STEP_W:0] w_len;
  logic [STEP_W:0] w_idx_inc;
  logic [STEP_W-1:0] w_next_idx;
  logic [STEP_W-1:0] w_rd_step;
  logic [NUM_VOICES-1:0] w_col;
  logic [NUM_VOICES-1:0] w_fire_trig;
  logic w_fire_choke;

  // r_tick_cnt holds the edges elapsed since the last fire; a step fires on
  // the edge where it has reached P-1, giving exactly P edges between fires.
  assign w_period_m1 = (step_period == 16'd0) ? 16'd0 : (step_period - 16'd1);
  assign w_len       = (pattern_len == '0) ? FULL_LEN : {1'b0, pattern_len};

  // Increment one bit wider so a full-length pattern wraps without aliasing.
  assign w_idx_inc  = {1'b0, r_step_index} + {{STEP_W{1'b0}}, 1'b1};
  assign w_next_idx = (w_idx_inc >= w_len) ? '0 : w_idx_inc[STEP_W-1:0];

  // Starting from IDLE always plays column 0; in RUN the upcoming column.
  assign w_rd_step = (r_state == SEQ_IDLE) ? '0 : w_next_idx;

  seq_pattern_ram #(
    .NUM_VOICES (NUM_VOICES),
    .NUM_STEPS  (NUM_STEPS)
  ) u_ram (
    .i_clk      (audio_tick),
    .i_reset    (reset),
    .i_wr_en    (wr_en),
    .i_wr_voice (wr_voice),
    .i_wr_step  (wr_step),
    .i_wr_data  (wr_data),
    .i_rd_step  (w_rd_step),
    .o_rd_col   (w_col)
  );

  // Closed hat wins over open hat in the same column: silence the open hat and choke it.
  always_comb begin
    w_fire_trig  = w_col;
    w_fire_choke = w_col[CLOSED_HAT];
    if (w_col[CLOSED_HAT]) begin
      w_fire_trig[OPEN_HAT] = 1'b0;
    end
  end

  // Next-state, step timing and pulse generation.
  always_comb begin
    w_state_nxt  = r_state;
    w_tick_nxt   = r_tick_cnt;
    w_idx_nxt    = r_step_index;
    w_trig_nxt   = '0;
    w_choke_nxt  = 1'b0;
    w_strobe_nxt = 1'b0;
    case (r_state)
      SEQ_IDLE: begin
        w_idx_nxt  = '0;
        w_tick_nxt = '0;
        if (run) begin
          w_state_nxt  = SEQ_RUN;
          w_trig_nxt   = w_fire_trig;
          w_choke_nxt  = w_fire_choke;
          w_strobe_nxt = 1'b1;
        end
      end
      SEQ_RUN: begin
        if (!run) begin
          w_state_nxt = SEQ_IDLE;
          w_idx_nxt   = '0;
          w_tick_nxt  = '0;
        end else if (r_tick_cnt >= w_period_m1) begin
          w_idx_nxt    = w_next_idx;
          w_trig_nxt   = w_fire_trig;
          w_choke_nxt  = w_fire_choke;
          w_strobe_nxt = 1'b1;
          w_tick_nxt   = '0;
        end else begin
          w_tick_nxt = r_tick_cnt + 16'd1;
        end
      end
      default: begin
        w_state_nxt = SEQ_IDLE;
        w_idx_nxt   = '0;
        w_tick_nxt  = '0;
      end
    endcase
  end

  // State and registered outputs; reset cuts pulses immediately.
  always_ff @(posedge audio_tick or posedge reset) begin
    if (reset) begin
      r_state       <= SEQ_IDLE;
      r_tick_cnt    <= '0;
      r_step_index  <= '0;
      r_trigger     <= '0;
      r_choke       <= 1'b0;
      r_step_strobe <= 1'b0;
      r_playing     <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_tick_cnt    <= w_tick_nxt;
      r_step_index  <= w_idx_nxt;
      r_trigger     <= w_trig_nxt;
      r_choke       <= w_choke_nxt;
      r_step_strobe <= w_strobe_nxt;
      r_playing     <= (w_state_nxt == SEQ_RUN);
    end
  end

  assign trigger     = r_trigger;
  assign choke       = r_choke;
  assign step_strobe = r_step_strobe;
  assign step_index  = r_step_index;
  assign playing     = r_playing;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_drum_step_sequencer.sv
// Self-checking bench for drum_step_sequencer: directed scenarios plus a
// randomized stretch, all compared each edge against a behavioural model.
module tb_drum_step_sequencer;

  logic        audio_tick = 1'b0;
  logic        reset;
  logic        run;
  logic [15:0] step_period;
  logic [3:0]  pattern_len;
  logic        wr_en;
  logic [1:0]  wr_voice;
  logic [3:0]  wr_step;
  logic        wr_data;
  logic [3:0]  trigger;
  logic        choke;
  logic        step_strobe;
  logic [3:0]  step_index;
  logic        playing;
  logic        dbg_state;

  int checks   = 0;
  int failures = 0;

  // Behavioural model: the grid, whether we are playing, the step playing,
  // and how many edges have passed since the last step fired.
  bit   m_grid [4][16];
  bit   m_playing;
  int   m_step;
  int   m_wait;
  logic [3:0] e_trig;
  logic       e_choke;
  logic       e_strobe;

  always #5 audio_tick = ~audio_tick;

  drum_step_sequencer dut (
    .audio_tick  (audio_tick),
    .reset       (reset),
    .run         (run),
    .step_period (step_period),
    .pattern_len (pattern_len),
    .wr_en       (wr_en),
    .wr_voice    (wr_voice),
    .wr_step     (wr_step),
    .wr_data     (wr_data),
    .trigger     (trigger),
    .choke       (choke),
    .step_strobe (step_strobe),
    .step_index  (step_index),
    .playing     (playing),
    .dbg_state   (dbg_state)
  );

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int v = 0; v < 4; v++)
      for (int s = 0; s < 16; s++) m_grid[v][s] = 1'b0;
    m_playing = 1'b0;
    m_step    = 0;
    m_wait    = 0;
    e_trig    = '0;
    e_choke   = 1'b0;
    e_strobe  = 1'b0;
  endtask

  function automatic bit fires_next();
    int p;
    p = (step_period == 0) ? 1 : int'(step_period);
    return run && (!m_playing || (m_wait + 1 >= p));
  endfunction

  // One audio edge: predict from pre-edge inputs, clock, then compare.
  task automatic tick();
    int  p;
    int  len;
    bit  fire;
    p    = (step_period == 0) ? 1 : int'(step_period);
    len  = (pattern_len == 0) ? 16 : int'(pattern_len);
    fire = 1'b0;
    e_trig   = '0;
    e_choke  = 1'b0;
    e_strobe = 1'b0;
    if (!run) begin
      m_playing = 1'b0;
      m_step    = 0;
      m_wait    = 0;
    end else if (!m_playing) begin
      m_playing = 1'b1;
      m_step    = 0;
      m_wait    = 0;
      fire      = 1'b1;
    end else if (m_wait + 1 >= p) begin
      m_step = (m_step + 1 >= len) ? 0 : m_step + 1;
      m_wait = 0;
      fire   = 1'b1;
    end else begin
      m_wait++;
    end
    if (fire) begin
      e_strobe = 1'b1;
      for (int v = 0; v < 4; v++) e_trig[v] = m_grid[v][m_step];
      if (m_grid[2][m_step]) begin
        e_choke   = 1'b1;
        e_trig[3] = 1'b0;
      end
    end
    if (wr_en) m_grid[wr_voice][wr_step] = wr_data;
    @(posedge audio_tick);
    #1;
    chk("trigger", 16'(trigger), 16'(e_trig));
    chk("choke", 16'(choke), 16'(e_choke));
    chk("step_strobe", 16'(step_strobe), 16'(e_strobe));
    chk("step_index", 16'(step_index), 16'(m_step));
    chk("playing", 16'(playing), 16'(m_playing));
  endtask

  task automatic write_cell(input int v, input int s, input bit d);
    wr_en    = 1'b1;
    wr_voice = 2'(v);
    wr_step  = 4'(s);
    wr_data  = d;
    tick();
    wr_en = 1'b0;
  endtask

  initial begin
    int target;
    // Clock/reset
    reset = 1'b1; run = 1'b0; step_period = 16'd4; pattern_len = 4'd0;
    wr_en = 1'b0; wr_voice = '0; wr_step = '0; wr_data = 1'b0;
    model_reset();
    repeat (2) @(posedge audio_tick);
    #1;
    chk("reset_trigger", 16'(trigger), 16'h0);
    chk("reset_choke", 16'(choke), 16'h0);
    chk("reset_strobe", 16'(step_strobe), 16'h0);
    chk("reset_index", 16'(step_index), 16'h0);
    chk("reset_playing", 16'(playing), 16'h0);
    reset = 1'b0;
    tick();

    // Empty grid, period 4: strobes every 4 edges, index wraps after 16 fires.
    run = 1'b1;
    repeat (70) tick();
    run = 1'b0;
    repeat (2) tick();

    // Kick on steps 0,4,8,12 with period 3.
    for (int s = 0; s < 16; s += 4) write_cell(0, s, 1'b1);
    step_period = 16'd3;
    run = 1'b1;
    repeat (55) tick();
    run = 1'b0;
    tick();

    // Closed and open hat together at step 1, open hat alone at step 2.
    write_cell(2, 1, 1'b1);
    write_cell(3, 1, 1'b1);
    write_cell(3, 2, 1'b1);
    step_period = 16'd2;
    run = 1'b1;
    repeat (12) tick();

    // Short pattern, then one fire per edge.
    pattern_len = 4'd5;
    repeat (16) tick();
    step_period = 16'd0;
    repeat (12) tick();
    step_period = 16'd1;
    repeat (6) tick();

    // Drop run mid-step, restart three edges later.
    pattern_len = 4'd0;
    step_period = 16'd3;
    for (int i = 0; i < 200 && !(m_step == 7 && m_wait == 1); i++) tick();
    chk("reached_step7", 16'(m_step), 16'd7);
    run = 1'b0;
    repeat (3) tick();
    run = 1'b1;
    repeat (4) tick();

    // Write to the column fired on the same edge: old value now, new value next visit.
    step_period = 16'd2;
    pattern_len = 4'd4;
    for (int i = 0; i < 20 && !fires_next(); i++) tick();
    target = (m_step + 1 >= 4) ? 0 : m_step + 1;
    write_cell(1, target, ~m_grid[1][target]);
    repeat (10) tick();

    // Randomized stretch.
    pattern_len = 4'd0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 39) == 0) run = ~run;
      if ($urandom_range(0, 29) == 0) step_period = 16'($urandom_range(0, 5));
      if ($urandom_range(0, 29) == 0) pattern_len = 4'($urandom_range(0, 15));
      wr_en    = ($urandom_range(0, 3) == 0);
      wr_voice = 2'($urandom_range(0, 3));
      wr_step  = 4'($urandom_range(0, 15));
      wr_data  = 1'($urandom_range(0, 1));
      tick();
    end
    wr_en = 1'b0;

    // Asynchronous reset while a trigger is high.
    run = 1'b0;
    tick();
    for (int s = 0; s < 16; s++) write_cell(0, s, 1'b1);
    step_period = 16'd1;
    pattern_len = 4'd0;
    run = 1'b1;
    repeat (3) tick();
    chk("kick_high_before_reset", 16'(trigger[0]), 16'h1);
    #2;
    reset = 1'b1;
    #1;
    chk("async_trigger", 16'(trigger), 16'h0);
    chk("async_strobe", 16'(step_strobe), 16'h0);
    chk("async_choke", 16'(choke), 16'h0);
    chk("async_index", 16'(step_index), 16'h0);
    chk("async_playing", 16'(playing), 16'h0);
    model_reset();
    @(negedge audio_tick);
    reset = 1'b0;
    repeat (8) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
